// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
// Holds the FSM state encoding and the output-width function.
package dec_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int out_w(input int n);
        return 32'sd1 << n;
    endfunction

endpackage : dec_pkg

// File: rtl/dec_onehot_comb.sv
// Combinational index-to-one-hot decoder built as a binary tree of mux_2x1 cells.
// Each tree level consumes one index bit and doubles the number of candidate lines.
module dec_onehot_comb
    import dec_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_idx,
    output logic [out_w(N)-1:0]  o_onehot
);

    localparam int OUT_W = out_w(N);

    // Level k lives at bit offset 2**k-1 and is 2**k bits wide; level 0 is the constant root.
    logic [2*OUT_W-2:0] w_tree;

    assign w_tree[0] = 1'b1;

    genvar k, i;
    generate
        for (k = 0; k < N; k++) begin : g_lvl
            localparam int W   = out_w(k);
            localparam int SRC = W - 1;
            localparam int DST = 2 * W - 1;
            for (i = 0; i < W; i++) begin : g_bit
                mux_2x1 u_lo (
                    .i_a   (w_tree[SRC+i]),
                    .i_b   (1'b0),
                    .i_sel (i_idx[k]),
                    .o_y   (w_tree[DST+i])
                );
                mux_2x1 u_hi (
                    .i_a   (1'b0),
                    .i_b   (w_tree[SRC+i]),
                    .i_sel (i_idx[k]),
                    .o_y   (w_tree[DST+W+i])
                );
            end
        end
    endgenerate

    assign o_onehot = w_tree[2*OUT_W-2:OUT_W-1];

endmodule : dec_onehot_comb

// File: rtl/mux_2x1.sv
// Library 2:1 multiplexer cell: o_y follows i_b when i_sel is high, else i_a.
module mux_2x1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule : mux_2x1

// File: rtl/dec_onehot_hold.sv
// Sequential binary-to-one-hot decoder: accepts an index via valid/ready and drives
// the selected line for HOLD cycles, then pulses done for one cycle.
module dec_onehot_hold
    import dec_pkg::*;
#(
    parameter int N    = 2,
    parameter int HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_idx,
    output logic                 in_ready,
    output logic [out_w(N)-1:0]  y,
    output logic                 y_valid,
    output logic                 done
);

    localparam int OUT_W = out_w(N);
    localparam int CW    = $clog2(HOLD + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic [OUT_W-1:0]   r_y;
    logic               r_y_valid;
    logic               r_done;

    state_e             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [OUT_W-1:0]   w_y_nxt;
    logic               w_y_valid_nxt;
    logic               w_done_nxt;
    logic [OUT_W-1:0]   w_onehot;

    dec_onehot_comb #(
        .N (N)
    ) u_dec (
        .i_idx    (in_idx),
        .o_onehot (w_onehot)
    );

    // State and output registers; rst has priority over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_y       <= {OUT_W{1'b0}};
            r_y_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down the window in HOLD.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_y_nxt       = w_onehot;
                    w_y_valid_nxt = 1'b1;
                    w_cnt_nxt     = CNT_LOAD;
                    w_state_nxt   = ST_HOLD;
                end else begin
                    w_y_nxt       = {OUT_W{1'b0}};
                    w_y_valid_nxt = 1'b0;
                    w_cnt_nxt     = CNT_ZERO;
                end
            end
            ST_HOLD: begin
                // The load value is HOLD-1, so the cnt==0 cycle is the last of HOLD high cycles.
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_y_nxt       = {OUT_W{1'b0}};
                    w_y_valid_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_cnt_nxt     = CNT_ZERO;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_y_nxt       = {OUT_W{1'b0}};
                w_y_valid_nxt = 1'b0;
                w_cnt_nxt     = CNT_ZERO;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (r_state == ST_IDLE);
    assign y        = r_y;
    assign y_valid  = r_y_valid;
    assign done     = r_done;

endmodule : dec_onehot_hold

// File: tb/tb_dec_onehot_hold.sv
// Bench for dec_onehot_hold: a HOLD=4 and a HOLD=1 instance share one directed stimulus
// and are checked every cycle against a remaining-cycles model plus literal expectations.
module tb_dec_onehot_hold;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_idx;

    logic       ready_a, yv_a, done_a;
    logic [3:0] y_a;
    logic       ready_b, yv_b, done_b;
    logic [3:0] y_b;

    int checks = 0;
    int errors = 0;

    int hold_len [2] = '{4, 1};
    int rem      [2];
    int midx     [2];
    bit mdone    [2];
    bit started  = 1'b0;

    always #5 clk = ~clk;

    dec_onehot_hold #(.N(2), .HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
        .in_ready(ready_a), .y(y_a), .y_valid(yv_a), .done(done_a)
    );

    dec_onehot_hold #(.N(2), .HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx),
        .in_ready(ready_b), .y(y_b), .y_valid(yv_b), .done(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a window is "remaining cycles of y high"; ready exactly when none remain.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rem[d]   = 0;
                mdone[d] = 1'b0;
            end else if (rem[d] == 0) begin
                mdone[d] = 1'b0;
                if (in_valid) begin
                    rem[d]  = hold_len[d];
                    midx[d] = int'(in_idx);
                end
            end else begin
                mdone[d] = (rem[d] == 1);
                rem[d]   = rem[d] - 1;
            end
        end
        started = 1'b1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("a_y",     {28'd0, y_a},     (rem[0] > 0) ? (32'd1 << midx[0]) : 32'd0);
            chk("a_yv",    {31'd0, yv_a},    {31'd0, rem[0] > 0});
            chk("a_done",  {31'd0, done_a},  {31'd0, mdone[0]});
            chk("a_ready", {31'd0, ready_a}, {31'd0, rem[0] == 0});
            chk("a_yv_or", {31'd0, yv_a},    {31'd0, |y_a});
            chk("b_y",     {28'd0, y_b},     (rem[1] > 0) ? (32'd1 << midx[1]) : 32'd0);
            chk("b_yv",    {31'd0, yv_b},    {31'd0, rem[1] > 0});
            chk("b_done",  {31'd0, done_b},  {31'd0, mdone[1]});
            chk("b_ready", {31'd0, ready_b}, {31'd0, rem[1] == 0});
            chk("b_yv_or", {31'd0, yv_b},    {31'd0, |y_b});
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_idx   = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_y",     {28'd0, y_a},     32'h0);
        chk("rst_yv",    {31'd0, yv_a},    32'h0);
        chk("rst_done",  {31'd0, done_a},  32'h0);
        chk("rst_ready", {31'd0, ready_a}, 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Single request idx=2: four cycles of 0100, then a done pulse.
        in_valid = 1'b1;
        in_idx   = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_y",     {28'd0, y_a},     32'h4);
            chk("t2_ready", {31'd0, ready_a}, 32'h0);
            @(negedge clk);
        end
        chk("t2_y_end", {28'd0, y_a},    32'h0);
        chk("t2_done",  {31'd0, done_a}, 32'h1);
        @(negedge clk);
        chk("t2_done_low", {31'd0, done_a}, 32'h0);

        // Request idx=1, then idx=3 offered throughout the window must be ignored.
        in_valid = 1'b1;
        in_idx   = 2'd1;
        @(negedge clk);
        in_idx = 2'd3;
        for (int i = 0; i < 4; i++) begin
            chk("t3_y", {28'd0, y_a}, 32'h2);
            @(negedge clk);
        end
        chk("t3_y_end", {28'd0, y_a}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);

        // in_valid held high: idx=0 window, then idx=3 accepted in the done cycle.
        in_valid = 1'b1;
        in_idx   = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t4_y0", {28'd0, y_a}, 32'h1);
            @(negedge clk);
        end
        chk("t4_gap",   {28'd0, y_a},     32'h0);
        chk("t4_ready", {31'd0, ready_a}, 32'h1);
        in_idx = 2'd3;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t4_y3", {28'd0, y_a}, 32'h8);
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        chk("t4_done", {31'd0, done_a}, 32'h1);
        @(negedge clk);

        // Reset in the second hold cycle clears y and suppresses done.
        in_valid = 1'b1;
        in_idx   = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5_y", {28'd0, y_a}, 32'h8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_y_clr", {28'd0, y_a},     32'h0);
        chk("t5_done",  {31'd0, done_a},  32'h0);
        chk("t5_ready", {31'd0, ready_a}, 32'h1);
        @(negedge clk);
        chk("t5_done_next", {31'd0, done_a}, 32'h0);

        // HOLD=1 instance: back-to-back sweep of every index with one idle cycle between.
        in_valid = 1'b1;
        in_idx   = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t6_y",  {28'd0, y_b},  32'd1 << i);
            chk("t6_yv", {31'd0, yv_b}, 32'h1);
            @(negedge clk);
            chk("t6_gap",  {28'd0, y_b},    32'h0);
            chk("t6_done", {31'd0, done_b}, 32'h1);
            if (i < 3) in_idx = 2'(i + 1);
            else in_valid = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dec_onehot_hold
